// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared types and constants for the 5-stage core's sequencing control.
//   REG_AW_DEF / CNT_W_DEF : default register-index and counter widths
//   FWD_*                  : ALU operand source select encodings
//   stage_tag_t            : shadow tag carried by every pipeline stage
//   ex_tag_t               : EX stage tag plus the source operand indices
// -----------------------------------------------------------------------------
package core_pkg;

    localparam int REG_AW_DEF = 5;
    localparam int CNT_W_DEF  = 32;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    typedef logic [REG_AW_DEF-1:0] reg_idx_t;

    typedef struct packed {
        logic     valid;
        reg_idx_t rd;
        logic     reg_write;
        logic     mem_read;
    } stage_tag_t;

    typedef struct packed {
        stage_tag_t tag;
        reg_idx_t   rs1;
        reg_idx_t   rs2;
        logic       use_rs1;
        logic       use_rs2;
    } ex_tag_t;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// -----------------------------------------------------------------------------
// fwd_sel
// Operand-forwarding select for one EX source index. Purely combinational.
//   use_i          : EX holds a valid instruction that reads this source
//   rs_i           : source register index
//   mem_tag_i      : shadow tag of the instruction in MEM
//   wb_valid_i, wb_rd_i, wb_reg_write_i : shadow tag fields of WB
//   sel_o          : FWD_RF / FWD_EXMEM / FWD_MEMWB
// -----------------------------------------------------------------------------
module fwd_sel
    import core_pkg::*;
(
    input  logic       use_i,
    input  reg_idx_t   rs_i,
    input  stage_tag_t mem_tag_i,
    input  logic       wb_valid_i,
    input  reg_idx_t   wb_rd_i,
    input  logic       wb_reg_write_i,
    output logic [1:0] sel_o
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path leaves it unassigned and no latch is inferred.
        sel_o = FWD_RF;
        // x0 is hard-wired zero and is never forwarded.
        if (use_i && (rs_i != '0)) begin
            // A load in MEM has no data yet; load-use stalling guarantees the
            // consumer instead meets it in WB.
            if (mem_tag_i.valid && mem_tag_i.reg_write && !mem_tag_i.mem_read &&
                (mem_tag_i.rd == rs_i)) begin
                sel_o = FWD_EXMEM;
            end else if (wb_valid_i && wb_reg_write_i && (wb_rd_i == rs_i)) begin
                sel_o = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Sequencing controller for the IF/ID/EX/MEM/WB core. Tracks a shadow copy of
// the EX/MEM/WB register tags and produces stall/flush enables, EX operand
// forwarding selects and stall/flush performance counters.
//   clk, rst (sync, active-high)
//   id_*            : decoded fields of the instruction sitting in IF/ID
//   ex_branch_taken : taken branch/jump resolved in EX
//   mem_stall       : data memory not ready; freezes the whole pipe
//   pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en : stage controls
//   fwd_a, fwd_b    : ALU operand sources for rs1 / rs2
//   ex_valid, mem_valid, wb_valid : shadow stage valid bits
//   stall_cnt, flush_cnt          : wrapping performance counters
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
    import core_pkg::*;
#(
    // Shadow tags are sized by the package; REG_AW must match REG_AW_DEF.
    parameter int REG_AW = REG_AW_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              ex_branch_taken,
    input  logic              mem_stall,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              ifid_flush,
    output logic              idex_en,
    output logic              idex_flush,
    output logic              exmem_en,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              ex_valid,
    output logic              mem_valid,
    output logic              wb_valid,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    ex_tag_t    ex_q;
    stage_tag_t mem_q;
    // WB only needs what forwarding looks at; whether it was a load no longer
    // matters once the data is on the writeback bus.
    logic       wb_valid_q;
    reg_idx_t   wb_rd_q;
    logic       wb_reg_write_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    logic load_use;
    logic stall_inc;
    logic flush_inc;

    assign load_use = ex_q.tag.valid && ex_q.tag.mem_read && (ex_q.tag.rd != '0) &&
                      id_valid &&
                      ((id_use_rs1 && (id_rs1 == ex_q.tag.rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_q.tag.rd)));

    // Priority: reset, memory stall, taken branch, load-use, normal flow.
    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b0;
        idex_en    = 1'b1;
        idex_flush = 1'b0;
        exmem_en   = 1'b1;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        if (rst) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            exmem_en   = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (mem_stall) begin
            // The branch (if any) stays in EX and is acted on after release.
            pc_en     = 1'b0;
            ifid_en   = 1'b0;
            idex_en   = 1'b0;
            exmem_en  = 1'b0;
            stall_inc = 1'b1;
        end else if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            flush_inc  = 1'b1;
        end else if (load_use) begin
            // Hold PC and IF/ID, let the load move on, insert one bubble.
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            stall_inc  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst) begin
            ex_q           <= '0;
            mem_q          <= '0;
            wb_valid_q     <= 1'b0;
            wb_rd_q        <= '0;
            wb_reg_write_q <= 1'b0;
            stall_cnt_q    <= '0;
            flush_cnt_q    <= '0;
        end else begin
            if (exmem_en) begin
                mem_q          <= ex_q.tag;
                wb_valid_q     <= mem_q.valid;
                wb_rd_q        <= mem_q.rd;
                wb_reg_write_q <= mem_q.reg_write;
            end
            if (idex_flush) begin
                ex_q <= '0;
            end else if (idex_en) begin
                ex_q.tag.valid     <= id_valid;
                ex_q.tag.rd        <= id_rd;
                ex_q.tag.reg_write <= id_reg_write;
                ex_q.tag.mem_read  <= id_mem_read;
                ex_q.rs1           <= id_rs1;
                ex_q.rs2           <= id_rs2;
                ex_q.use_rs1       <= id_use_rs1;
                ex_q.use_rs2       <= id_use_rs2;
            end
            if (stall_inc) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (flush_inc) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    fwd_sel u_fwd_a (
        .use_i          (!rst && ex_q.tag.valid && ex_q.use_rs1),
        .rs_i           (ex_q.rs1),
        .mem_tag_i      (mem_q),
        .wb_valid_i     (wb_valid_q),
        .wb_rd_i        (wb_rd_q),
        .wb_reg_write_i (wb_reg_write_q),
        .sel_o          (fwd_a)
    );

    fwd_sel u_fwd_b (
        .use_i          (!rst && ex_q.tag.valid && ex_q.use_rs2),
        .rs_i           (ex_q.rs2),
        .mem_tag_i      (mem_q),
        .wb_valid_i     (wb_valid_q),
        .wb_rd_i        (wb_rd_q),
        .wb_reg_write_i (wb_reg_write_q),
        .sel_o          (fwd_b)
    );

    assign ex_valid  = ex_q.tag.valid;
    assign mem_valid = mem_q.valid;
    assign wb_valid  = wb_valid_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed bench for pipe_hazard_ctrl: forwarding distances, load-use bubble,
// taken branch, memory stall, x0 handling and reset mid-stream.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
    logic              id_use_rs1, id_use_rs2, id_reg_write, id_mem_read;
    logic              ex_branch_taken, mem_stall;
    logic              pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en;
    logic [1:0]        fwd_a, fwd_b;
    logic              ex_valid, mem_valid, wb_valid;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .id_rd           (id_rd),
        .id_reg_write    (id_reg_write),
        .id_mem_read     (id_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .mem_stall       (mem_stall),
        .pc_en           (pc_en),
        .ifid_en         (ifid_en),
        .ifid_flush      (ifid_flush),
        .idex_en         (idex_en),
        .idex_flush      (idex_flush),
        .exmem_en        (exmem_en),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b),
        .ex_valid        (ex_valid),
        .mem_valid       (mem_valid),
        .wb_valid        (wb_valid),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic u1, input logic u2, input logic [4:0] rd,
                            input logic rw, input logic mr);
        id_valid     = v;
        id_rs1       = rs1;
        id_rs2       = rs2;
        id_use_rs1   = u1;
        id_use_rs2   = u2;
        id_rd        = rd;
        id_reg_write = rw;
        id_mem_read  = mr;
    endtask

    task automatic id_nop;
        drive_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    // Advance one edge and step just past it before touching inputs.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drain;
        id_nop();
        repeat (3) tick();
    endtask

    // Watchdog: the flow below is bounded, this only guards against a hang.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        ex_branch_taken = 1'b0;
        mem_stall = 1'b0;
        id_nop();
        #1;
        // Reset outputs
        check("rst_en",    {pc_en, ifid_en, idex_en, exmem_en}, 4'b0000);
        check("rst_flush", {ifid_flush, idex_flush}, 2'b11);
        check("rst_fwd",   {fwd_a, fwd_b}, 4'b0000);
        tick();
        tick();
        check("rst_valids", {ex_valid, mem_valid, wb_valid}, 3'b000);
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_flush_cnt", flush_cnt, 0);
        rst = 1'b0;
        #1;
        check("first_en",    {pc_en, ifid_en, idex_en, exmem_en}, 4'b1111);
        check("first_flush", {ifid_flush, idex_flush}, 2'b00);
        check("first_fwd",   {fwd_a, fwd_b}, 4'b0000);

        // Back-to-back: add x5,x1,x2 ; sub x6,x5,x1
        drive_id(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0);
        tick();
        drive_id(1, 5'd5, 5'd1, 1, 1, 5'd6, 1, 0);
        #1;
        check("b2b_no_stall", {pc_en, ifid_en, idex_en, exmem_en}, 4'b1111);
        tick();
        id_nop();
        #1;
        check("b2b_fwd_a", fwd_a, 2'b01);
        check("b2b_fwd_b", fwd_b, 2'b00);
        check("b2b_stall_cnt", stall_cnt, 0);
        drain();

        // Distance 2: add x5 ; nop ; and x7,x5,x5
        drive_id(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0);
        tick();
        id_nop();
        tick();
        drive_id(1, 5'd5, 5'd5, 1, 1, 5'd7, 1, 0);
        tick();
        id_nop();
        #1;
        check("d2_fwd_a", fwd_a, 2'b10);
        check("d2_fwd_b", fwd_b, 2'b10);
        drain();

        // x5 written in both MEM and WB: the younger (MEM) value wins
        drive_id(1, 5'd3, 5'd4, 1, 1, 5'd5, 1, 0);
        tick();
        drive_id(1, 5'd3, 5'd4, 1, 1, 5'd5, 1, 0);
        tick();
        drive_id(1, 5'd5, 5'd0, 1, 0, 5'd10, 1, 0);
        tick();
        id_nop();
        #1;
        check("memwins_fwd_a", fwd_a, 2'b01);
        check("memwins_fwd_b", fwd_b, 2'b00);
        drain();

        // Load-use: lw x8 ; add x9,x8,x2
        drive_id(1, 5'd1, 5'd0, 1, 0, 5'd8, 1, 1);
        tick();
        drive_id(1, 5'd8, 5'd2, 1, 1, 5'd9, 1, 0);
        #1;
        check("lu_ctrl", {pc_en, ifid_en, idex_flush, exmem_en}, 4'b0011);
        tick();
        #1;
        check("lu_bubble_ex_valid", ex_valid, 1'b0);
        check("lu_stall_cnt", stall_cnt, 1);
        check("lu_release_pc_en", pc_en, 1'b1);
        tick();
        id_nop();
        #1;
        check("lu_fwd_a", fwd_a, 2'b10);
        check("lu_fwd_b", fwd_b, 2'b00);
        drain();

        // Taken branch in EX
        drive_id(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0);
        tick();
        drive_id(1, 5'd1, 5'd2, 1, 1, 5'd4, 1, 0);
        ex_branch_taken = 1'b1;
        #1;
        check("br_ctrl", {pc_en, ifid_flush, idex_flush, exmem_en}, 4'b1111);
        tick();
        ex_branch_taken = 1'b0;
        id_nop();
        #1;
        check("br_ex_valid", ex_valid, 1'b0);
        check("br_mem_valid", mem_valid, 1'b1);
        check("br_flush_cnt", flush_cnt, 1);
        drain();

        // Taken branch coinciding with a load-use pattern: branch wins
        drive_id(1, 5'd1, 5'd0, 1, 0, 5'd8, 1, 1);
        tick();
        drive_id(1, 5'd8, 5'd2, 1, 1, 5'd9, 1, 0);
        ex_branch_taken = 1'b1;
        #1;
        check("bl_ctrl", {pc_en, ifid_flush, idex_flush}, 3'b111);
        tick();
        ex_branch_taken = 1'b0;
        id_nop();
        #1;
        check("bl_stall_cnt", stall_cnt, 1);
        check("bl_flush_cnt", flush_cnt, 2);
        check("bl_ex_valid", ex_valid, 1'b0);
        drain();

        // mem_stall for 3 cycles with a taken branch waiting in EX
        drive_id(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0);
        tick();
        id_nop();
        mem_stall = 1'b1;
        ex_branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("ms_en",    {pc_en, ifid_en, idex_en, exmem_en}, 4'b0000);
            check("ms_flush", {ifid_flush, idex_flush}, 2'b00);
            tick();
        end
        check("ms_stall_cnt", stall_cnt, 4);
        check("ms_flush_cnt", flush_cnt, 2);
        check("ms_ex_frozen", ex_valid, 1'b1);
        mem_stall = 1'b0;
        #1;
        check("msr_ctrl", {pc_en, ifid_flush, idex_flush}, 3'b111);
        tick();
        ex_branch_taken = 1'b0;
        #1;
        check("msr_flush_cnt", flush_cnt, 3);
        check("msr_stall_cnt", stall_cnt, 4);
        check("msr_ex_valid", ex_valid, 1'b0);
        drain();

        // x0 destination is never forwarded
        drive_id(1, 5'd1, 5'd2, 1, 1, 5'd0, 1, 0);
        tick();
        drive_id(1, 5'd0, 5'd0, 1, 1, 5'd11, 1, 0);
        tick();
        id_nop();
        #1;
        check("x0_fwd", {fwd_a, fwd_b}, 4'b0000);
        drain();

        // lw x0 followed by a reader of x0: no load-use stall
        drive_id(1, 5'd1, 5'd0, 1, 0, 5'd0, 1, 1);
        tick();
        drive_id(1, 5'd0, 5'd0, 1, 1, 5'd12, 1, 0);
        #1;
        check("x0_no_stall", {pc_en, ifid_en, idex_flush}, 3'b110);
        tick();
        id_nop();
        #1;
        check("x0_stall_cnt", stall_cnt, 4);
        drain();

        // Reset mid-stream
        drive_id(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0);
        tick();
        drive_id(1, 5'd1, 5'd2, 1, 1, 5'd6, 1, 0);
        tick();
        check("pre_rst_valids", {ex_valid, mem_valid, wb_valid}, 3'b110);
        rst = 1'b1;
        #1;
        check("mid_rst_en", {pc_en, ifid_en, idex_en, exmem_en}, 4'b0000);
        tick();
        check("mid_rst_valids", {ex_valid, mem_valid, wb_valid}, 3'b000);
        check("mid_rst_stall_cnt", stall_cnt, 0);
        check("mid_rst_flush_cnt", flush_cnt, 0);
        rst = 1'b0;
        id_nop();
        #1;
        check("post_rst_en", {pc_en, ifid_en, idex_en, exmem_en}, 4'b1111);
        check("post_rst_fwd", {fwd_a, fwd_b}, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
